// File: rtl/router_pkg.sv
// router_pkg
//   Shared definitions for the N-channel router control FSM:
//     router_state_e        - 4-bit state encoding
//     ROUTER_DEFAULT_NUM_CH - default number of destination FIFOs
//     addr_in_range()       - header destination check against NUM_CH
package router_pkg;

    localparam int ROUTER_DEFAULT_NUM_CH = 3;

    typedef enum logic [3:0] {
        DECODE_ADDRESS     = 4'd0,
        LOAD_FIRST_DATA    = 4'd1,
        LOAD_DATA          = 4'd2,
        FIFO_FULL_STATE    = 4'd3,
        LOAD_AFTER_FULL    = 4'd4,
        LOAD_PARITY        = 4'd5,
        CHECK_PARITY_ERROR = 4'd6,
        WAIT_TILL_EMPTY    = 4'd7,
        DROP_PACKET        = 4'd8
    } router_state_e;

    function automatic logic addr_in_range(input logic [31:0] addr, input int num_ch);
        return addr < 32'(num_ch);
    endfunction

endpackage

// File: rtl/router_fsm_nch_if.sv
// router_fsm_nch_if
//   Groups the router FSM inputs (source handshake, FIFO status, register
//   block strobes) and its state/strobe outputs.
//   modport master : the FSM side (drives strobes, samples status)
//   modport slave  : the environment side (source, FIFOs, register block)
interface router_fsm_nch_if #(
    parameter int NUM_CH = 3,
    parameter int ADDR_W = 2
);
    logic              pkt_valid;
    logic [ADDR_W-1:0] din;
    logic [NUM_CH-1:0] fifo_full;
    logic [NUM_CH-1:0] fifo_empty;
    logic [NUM_CH-1:0] soft_rst;
    logic              parity_done;
    logic              low_pkt_valid;

    logic              wr_en_req;
    logic              detect_addr;
    logic              lfd_state;
    logic              ld_state;
    logic              laf_state;
    logic              full_state;
    logic              rst_int_reg;
    logic              busy;
    logic              drop_state;
    logic [ADDR_W-1:0] dest_q;
    logic              wait_timeout;

    modport master (
        input  pkt_valid, din, fifo_full, fifo_empty, soft_rst, parity_done, low_pkt_valid,
        output wr_en_req, detect_addr, lfd_state, ld_state, laf_state, full_state,
               rst_int_reg, busy, drop_state, dest_q, wait_timeout
    );

    modport slave (
        output pkt_valid, din, fifo_full, fifo_empty, soft_rst, parity_done, low_pkt_valid,
        input  wr_en_req, detect_addr, lfd_state, ld_state, laf_state, full_state,
               rst_int_reg, busy, drop_state, dest_q, wait_timeout
    );

endinterface

// File: rtl/router_fsm_nch.sv
// router_fsm_nch
//   Packet-load sequencer for an input router feeding NUM_CH destination
//   FIFOs. All status gating (full, empty, soft reset) uses only the latched
//   destination channel. Headers addressing a non-existent channel are
//   dropped.
//   Ports: clk, rst (synchronous, active-high), bus (router_fsm_nch_if.master).
//   Optional macro ROUTER_WAIT_TIMEOUT_EN: drop the packet after WAIT_TIMEOUT
//   cycles in WAIT_TILL_EMPTY and pulse wait_timeout; otherwise the wait is
//   unbounded and wait_timeout is tied 0.
//
//   state              | meaning
//   DECODE_ADDRESS     | idle, waiting for a header byte
//   WAIT_TILL_EMPTY    | destination FIFO not yet empty
//   LOAD_FIRST_DATA    | header byte written
//   LOAD_DATA          | payload bytes being written
//   FIFO_FULL_STATE    | destination full, source held
//   LOAD_AFTER_FULL    | resume after full
//   LOAD_PARITY        | parity byte written
//   CHECK_PARITY_ERROR | parity compare in register block
//   DROP_PACKET        | discarding a packet with an invalid address
module router_fsm_nch
    import router_pkg::*;
#(
    parameter int NUM_CH       = ROUTER_DEFAULT_NUM_CH,
    parameter int ADDR_W       = 2,
    parameter int WAIT_TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    router_fsm_nch_if.master  bus
);

    // Status vectors widened to the full address span so any dest/din value
    // indexes in range; the padding bits are never selected by a valid channel.
    localparam int ADDR_SPAN = 2 ** ADDR_W;

    logic [ADDR_SPAN-1:0] full_ext, empty_ext, srst_ext;
    assign full_ext  = ADDR_SPAN'(bus.fifo_full);
    assign empty_ext = ADDR_SPAN'(bus.fifo_empty);
    assign srst_ext  = ADDR_SPAN'(bus.soft_rst);

    router_state_e     state_q, state_d;
    logic [ADDR_W-1:0] dest_q, dest_d;

    logic dest_full, dest_empty, dest_srst, hdr_empty, hdr_ok;
    assign dest_full  = full_ext[dest_q];
    assign dest_empty = empty_ext[dest_q];
    assign dest_srst  = srst_ext[dest_q];
    assign hdr_empty  = empty_ext[bus.din];
    assign hdr_ok     = addr_in_range(32'(bus.din), NUM_CH);

`ifdef ROUTER_WAIT_TIMEOUT_EN
    localparam int CNT_W = $clog2(WAIT_TIMEOUT + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             wto_q, wto_d;
    logic             timeout_hit;

    // Any cycle outside the wait state clears the count, so it starts at 0
    // on every entry.
    assign cnt_d       = (state_q == WAIT_TILL_EMPTY) ? cnt_q + CNT_W'(1) : '0;
    assign timeout_hit = (state_q == WAIT_TILL_EMPTY) && (cnt_q == CNT_W'(WAIT_TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            wto_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            wto_q <= wto_d;
        end
    end

    assign bus.wait_timeout = wto_q;
`else
    assign bus.wait_timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= DECODE_ADDRESS;
            dest_q  <= '0;
        end else begin
            state_q <= state_d;
            dest_q  <= dest_d;
        end
    end

    always_comb begin
        state_d = state_q;
        dest_d  = dest_q;
`ifdef ROUTER_WAIT_TIMEOUT_EN
        wto_d   = 1'b0;
`endif
        case (state_q)
            DECODE_ADDRESS: begin
                if (bus.pkt_valid) begin
                    if (!hdr_ok) begin
                        state_d = DROP_PACKET;
                    end else begin
                        dest_d  = bus.din;
                        state_d = hdr_empty ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
                    end
                end
            end
            WAIT_TILL_EMPTY: begin
                if (dest_empty) begin
                    state_d = LOAD_FIRST_DATA;
                end
`ifdef ROUTER_WAIT_TIMEOUT_EN
                else if (timeout_hit) begin
                    state_d = DROP_PACKET;
                    wto_d   = 1'b1;
                end
`endif
            end
            LOAD_FIRST_DATA: state_d = LOAD_DATA;
            LOAD_DATA: begin
                if (dest_full)           state_d = FIFO_FULL_STATE;
                else if (!bus.pkt_valid) state_d = LOAD_PARITY;
            end
            FIFO_FULL_STATE: begin
                if (!dest_full) state_d = LOAD_AFTER_FULL;
            end
            LOAD_AFTER_FULL: begin
                if (bus.parity_done)        state_d = DECODE_ADDRESS;
                else if (bus.low_pkt_valid) state_d = LOAD_PARITY;
                else                        state_d = LOAD_DATA;
            end
            LOAD_PARITY:        state_d = CHECK_PARITY_ERROR;
            CHECK_PARITY_ERROR: state_d = dest_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
            DROP_PACKET: begin
                if (!bus.pkt_valid) state_d = DECODE_ADDRESS;
            end
            default: state_d = DECODE_ADDRESS;
        endcase

        // Soft reset of the active channel aborts the packet; idle and drop
        // have no channel to abort.
        if (dest_srst && state_q != DECODE_ADDRESS && state_q != DROP_PACKET) begin
            state_d = DECODE_ADDRESS;
`ifdef ROUTER_WAIT_TIMEOUT_EN
            wto_d   = 1'b0;
`endif
        end
    end

    always_comb begin
        bus.detect_addr = 1'b0;
        bus.lfd_state   = 1'b0;
        bus.ld_state    = 1'b0;
        bus.laf_state   = 1'b0;
        bus.full_state  = 1'b0;
        bus.rst_int_reg = 1'b0;
        bus.wr_en_req   = 1'b0;
        bus.busy        = 1'b0;
        bus.drop_state  = 1'b0;
        case (state_q)
            DECODE_ADDRESS:  bus.detect_addr = 1'b1;
            WAIT_TILL_EMPTY: bus.busy        = 1'b1;
            LOAD_FIRST_DATA: begin
                bus.lfd_state = 1'b1;
                bus.busy      = 1'b1;
            end
            LOAD_DATA: begin
                bus.ld_state  = 1'b1;
                bus.wr_en_req = 1'b1;
            end
            FIFO_FULL_STATE: begin
                bus.full_state = 1'b1;
                bus.busy       = 1'b1;
            end
            LOAD_AFTER_FULL: begin
                bus.laf_state = 1'b1;
                bus.wr_en_req = 1'b1;
                bus.busy      = 1'b1;
            end
            LOAD_PARITY: begin
                bus.wr_en_req = 1'b1;
                bus.busy      = 1'b1;
            end
            CHECK_PARITY_ERROR: begin
                bus.rst_int_reg = 1'b1;
                bus.busy        = 1'b1;
            end
            DROP_PACKET: bus.drop_state = 1'b1;
            default: ;
        endcase
    end

    assign bus.dest_q = dest_q;

endmodule

// File: tb/tb_router_fsm_nch.sv
// tb_router_fsm_nch
//   Scoreboard bench for router_fsm_nch (NUM_CH=3, ADDR_W=2, WAIT_TIMEOUT=4).
//   Each step drives inputs and queues the state/destination expected after
//   the next clock edge; a negedge monitor pops and compares the outputs.
module tb_router_fsm_nch;
    import router_pkg::*;

    localparam int NUM_CH       = 3;
    localparam int ADDR_W       = 2;
    localparam int WAIT_TIMEOUT = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    router_fsm_nch_if #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W)) bus ();

    router_fsm_nch #(
        .NUM_CH      (NUM_CH),
        .ADDR_W      (ADDR_W),
        .WAIT_TIMEOUT(WAIT_TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        string             tag;
        router_state_e     st;
        logic [ADDR_W-1:0] dest;
        logic              wto;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // {detect, lfd, ld, laf, full, rst_int, wr_en, busy, drop, wait_timeout}
    function automatic logic [9:0] exp_outs(input router_state_e st, input logic wto);
        logic [9:0] v;
        case (st)
            DECODE_ADDRESS:     v = 10'b1000000000;
            LOAD_FIRST_DATA:    v = 10'b0100000100;
            LOAD_DATA:          v = 10'b0010001000;
            LOAD_AFTER_FULL:    v = 10'b0001001100;
            FIFO_FULL_STATE:    v = 10'b0000100100;
            CHECK_PARITY_ERROR: v = 10'b0000010100;
            LOAD_PARITY:        v = 10'b0000001100;
            WAIT_TILL_EMPTY:    v = 10'b0000000100;
            DROP_PACKET:        v = 10'b0000000010;
            default:            v = 10'b0000000000;
        endcase
        v[0] = wto;
        return v;
    endfunction

    exp_t       mon_e;
    logic [9:0] mon_obs;
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            mon_e   = sb_q.pop_front();
            mon_obs = {bus.detect_addr, bus.lfd_state, bus.ld_state, bus.laf_state, bus.full_state,
                       bus.rst_int_reg, bus.wr_en_req, bus.busy, bus.drop_state, bus.wait_timeout};
            check_val({mon_e.tag, "/outs"}, 32'(mon_obs), 32'(exp_outs(mon_e.st, mon_e.wto)));
            check_val({mon_e.tag, "/dest"}, 32'(bus.dest_q), 32'(mon_e.dest));
        end
    end

    task automatic step(input string tag, input router_state_e st, input logic [ADDR_W-1:0] dest,
                        input logic wto = 1'b0);
        exp_t e;
        e.tag  = tag;
        e.st   = st;
        e.dest = dest;
        e.wto  = wto;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst               = 1'b1;
        bus.pkt_valid     = 1'b1;
        bus.din           = 2'd2;
        bus.fifo_full     = 3'b000;
        bus.fifo_empty    = 3'b111;
        bus.soft_rst      = 3'b000;
        bus.parity_done   = 1'b0;
        bus.low_pkt_valid = 1'b0;
        #1;

        // reset held with pkt_valid high
        step("rst0", DECODE_ADDRESS, 2'd0);
        step("rst1", DECODE_ADDRESS, 2'd0);
        rst = 1'b0;

        // clean packet to channel 2
        bus.fifo_empty = 3'b100;
        step("cln_hdr", LOAD_FIRST_DATA, 2'd2);
        for (int i = 0; i < 4; i++) step($sformatf("cln_ld%0d", i), LOAD_DATA, 2'd2);
        bus.pkt_valid = 1'b0;
        step("cln_lp",  LOAD_PARITY,        2'd2);
        step("cln_chk", CHECK_PARITY_ERROR, 2'd2);
        step("cln_end", DECODE_ADDRESS,     2'd2);

        // wait only on the latched channel
        bus.pkt_valid  = 1'b1;
        bus.din        = 2'd1;
        bus.fifo_empty = 3'b101;
        step("wt_hdr", WAIT_TILL_EMPTY, 2'd1);
        step("wt_0",   WAIT_TILL_EMPTY, 2'd1);
        step("wt_1",   WAIT_TILL_EMPTY, 2'd1);
        bus.fifo_empty = 3'b111;
        step("wt_lfd", LOAD_FIRST_DATA, 2'd1);
        step("wt_ld",  LOAD_DATA,       2'd1);
        bus.pkt_valid = 1'b0;
        step("wt_lp",  LOAD_PARITY,        2'd1);
        step("wt_chk", CHECK_PARITY_ERROR, 2'd1);
        step("wt_end", DECODE_ADDRESS,     2'd1);

        // full paths on channel 0
        bus.pkt_valid = 1'b1;
        bus.din       = 2'd0;
        step("fl_hdr", LOAD_FIRST_DATA, 2'd0);
        step("fl_ld0", LOAD_DATA,       2'd0);
        bus.fifo_full = 3'b010;
        step("fl_other", LOAD_DATA,     2'd0);
        bus.fifo_full = 3'b001;
        step("fl_full0", FIFO_FULL_STATE, 2'd0);
        bus.fifo_full = 3'b000;
        step("fl_laf0",  LOAD_AFTER_FULL, 2'd0);
        step("fl_ld1",   LOAD_DATA,       2'd0);
        bus.fifo_full = 3'b001;
        step("fl_full1", FIFO_FULL_STATE, 2'd0);
        step("fl_hold",  FIFO_FULL_STATE, 2'd0);
        bus.fifo_full     = 3'b000;
        bus.low_pkt_valid = 1'b1;
        step("fl_laf1",  LOAD_AFTER_FULL, 2'd0);
        step("fl_lp",    LOAD_PARITY,     2'd0);
        bus.low_pkt_valid = 1'b0;
        bus.pkt_valid     = 1'b0;
        bus.fifo_full     = 3'b001;
        step("fl_chk",   CHECK_PARITY_ERROR, 2'd0);
        step("fl_full2", FIFO_FULL_STATE,    2'd0);
        bus.fifo_full   = 3'b000;
        bus.parity_done = 1'b1;
        step("fl_laf2",  LOAD_AFTER_FULL,    2'd0);
        step("fl_pdone", DECODE_ADDRESS,     2'd0);
        bus.parity_done = 1'b0;

        // invalid address
        bus.pkt_valid = 1'b1;
        bus.din       = 2'd3;
        step("inv_hdr",  DROP_PACKET,    2'd0);
        step("inv_hold", DROP_PACKET,    2'd0);
        bus.pkt_valid = 1'b0;
        step("inv_end",  DECODE_ADDRESS, 2'd0);

        // soft reset on other vs. latched channel
        bus.pkt_valid = 1'b1;
        bus.din       = 2'd2;
        step("sr_hdr", LOAD_FIRST_DATA, 2'd2);
        step("sr_ld",  LOAD_DATA,       2'd2);
        bus.soft_rst = 3'b010;
        step("sr_other", LOAD_DATA,     2'd2);
        bus.soft_rst = 3'b100;
        step("sr_hit",   DECODE_ADDRESS, 2'd2);
        bus.soft_rst  = 3'b000;
        bus.pkt_valid = 1'b0;
        step("sr_idle",  DECODE_ADDRESS, 2'd2);

        // soft reset has no effect while dropping
        bus.pkt_valid = 1'b1;
        bus.din       = 2'd3;
        bus.soft_rst  = 3'b100;
        step("srd_hdr",  DROP_PACKET,    2'd2);
        step("srd_hold", DROP_PACKET,    2'd2);
        bus.pkt_valid = 1'b0;
        bus.soft_rst  = 3'b000;
        step("srd_end",  DECODE_ADDRESS, 2'd2);

        // wait timeout
        bus.pkt_valid  = 1'b1;
        bus.din        = 2'd1;
        bus.fifo_empty = 3'b101;
        step("to_hdr", WAIT_TILL_EMPTY, 2'd1);
        bus.pkt_valid = 1'b0;
`ifdef ROUTER_WAIT_TIMEOUT_EN
        for (int i = 1; i < WAIT_TIMEOUT; i++) step($sformatf("to_w%0d", i), WAIT_TILL_EMPTY, 2'd1);
        step("to_drop", DROP_PACKET,    2'd1, 1'b1);
        step("to_end",  DECODE_ADDRESS, 2'd1, 1'b0);
`else
        for (int i = 1; i < 3 * WAIT_TIMEOUT; i++) step($sformatf("to_w%0d", i), WAIT_TILL_EMPTY, 2'd1);
        bus.fifo_empty = 3'b111;
        step("to_lfd", LOAD_FIRST_DATA, 2'd1);
        step("to_ld",  LOAD_DATA,       2'd1);
        step("to_lp",  LOAD_PARITY,     2'd1);
        step("to_chk", CHECK_PARITY_ERROR, 2'd1);
        step("to_end", DECODE_ADDRESS,  2'd1);
        bus.fifo_empty = 3'b101;
`endif

        // empty arriving on the last allowed wait cycle wins
        bus.pkt_valid = 1'b1;
        step("tw_hdr", WAIT_TILL_EMPTY, 2'd1);
        bus.pkt_valid = 1'b0;
        for (int i = 1; i < WAIT_TIMEOUT; i++) step($sformatf("tw_w%0d", i), WAIT_TILL_EMPTY, 2'd1);
        bus.fifo_empty = 3'b111;
        step("tw_lfd", LOAD_FIRST_DATA,    2'd1, 1'b0);
        step("tw_ld",  LOAD_DATA,          2'd1);
        step("tw_lp",  LOAD_PARITY,        2'd1);
        step("tw_chk", CHECK_PARITY_ERROR, 2'd1);
        step("tw_end", DECODE_ADDRESS,     2'd1);

        @(negedge clk);
        #1;
        check_val("sb_drain", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/router_fsm_nch.md
Name: router_fsm_nch

Overview:
Parametrised successor to the 1x3 router control FSM. It sequences packet loading from the router input into one of NUM_CH destination FIFOs and drives the register-block and synchroniser strobes. It fixes per-channel gating: wait, full and soft-reset decisions use only the latched destination channel. It adds invalid-address packet dropping and an optional wait timeout.

Parameters:
NUM_CH, 3, number of destination FIFOs (2..16)
ADDR_W, 2, width of the header destination field; must be ≥ max(1, $clog2(NUM_CH))
WAIT_TIMEOUT, 16, cycles allowed in WAIT_TILL_EMPTY before the packet is dropped (used only with ROUTER_WAIT_TIMEOUT_EN)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
pkt_valid  in  1  packet byte valid from source
din  in  ADDR_W  destination field of header byte
fifo_full  in  NUM_CH  per-channel FIFO full
fifo_empty  in  NUM_CH  per-channel FIFO empty
soft_rst  in  NUM_CH  per-channel soft reset from synchroniser
parity_done  in  1  parity byte written (register block)
low_pkt_valid  in  1  pkt_valid fell while full (register block)
wr_en_req  out  1  write request to synchroniser
detect_addr  out  1  in DECODE_ADDRESS
lfd_state / ld_state / laf_state / full_state  out  1 each  state indicators
rst_int_reg  out  1  in CHECK_PARITY_ERROR
busy  out  1  source must hold its byte
drop_state  out  1  packet being discarded
dest_q  out  ADDR_W  latched destination channel
wait_timeout  out  1  one-cycle pulse on timeout (tied 0 when the feature is off)

Behaviour:
- Reset state is DECODE_ADDRESS. dest_q=0. detect_addr=1. All other outputs are 0.
- Priority: rst, then soft_rst[dest_q] (only outside DECODE_ADDRESS and DROP_PACKET), then next-state logic. soft_rst on other channels is ignored.
- State register is 4 bits. All outputs are Moore outputs, decoded from the registered state and dest_q.
- DECODE_ADDRESS (pkt_valid=1):
  - din ≥ NUM_CH → DROP_PACKET.
  - Otherwise latch dest_q=din. fifo_empty[din]=1 → LOAD_FIRST_DATA; fifo_empty[din]=0 → WAIT_TILL_EMPTY.
  - With pkt_valid=0, stay.
- WAIT_TILL_EMPTY: fifo_empty[dest_q]=1 → LOAD_FIRST_DATA, else stay. Other channels going empty has no effect.
- LOAD_FIRST_DATA → LOAD_DATA unconditionally.
- LOAD_DATA:
  - fifo_full[dest_q] → FIFO_FULL_STATE.
  - else !pkt_valid → LOAD_PARITY.
  - else stay.
- FIFO_FULL_STATE: !fifo_full[dest_q] → LOAD_AFTER_FULL, else stay.
- LOAD_AFTER_FULL:
  - parity_done → DECODE_ADDRESS.
  - else low_pkt_valid → LOAD_PARITY.
  - else → LOAD_DATA.
- LOAD_PARITY → CHECK_PARITY_ERROR.
- CHECK_PARITY_ERROR: fifo_full[dest_q] → FIFO_FULL_STATE, else DECODE_ADDRESS.
- DROP_PACKET: stay while pkt_valid=1; pkt_valid=0 → DECODE_ADDRESS. No writes are requested.
- Output decode:
  - wr_en_req = LOAD_DATA | LOAD_PARITY | LOAD_AFTER_FULL.
  - busy = every state except DECODE_ADDRESS, LOAD_DATA and DROP_PACKET.
  - drop_state = DROP_PACKET.
- Unreachable encodings recover to DECODE_ADDRESS on the next cycle.
- dest_q holds its value through the whole packet and changes only on an accepted header.

Optional Feature:
ROUTER_WAIT_TIMEOUT_EN
- Defined:
  - A counter of width $clog2(WAIT_TIMEOUT+1) clears on entry to WAIT_TILL_EMPTY and increments each cycle spent there.
  - When count reaches WAIT_TIMEOUT-1 with fifo_empty[dest_q]=0, next state is DROP_PACKET and wait_timeout pulses for one cycle.
  - fifo_empty[dest_q]=1 in the same cycle wins; LOAD_FIRST_DATA is taken and there is no pulse.
- Undefined: no counter; WAIT_TILL_EMPTY waits indefinitely; wait_timeout is tied 0.

Decomposition:
- Package router_pkg holds:
  - the state enum typedef router_state_e (4-bit, values above);
  - ROUTER_DEFAULT_NUM_CH = 3;
  - a function to check an address against NUM_CH.
- A separate sub-module is not needed. The timeout counter is inline, inside the macro guard.

Test Plan:
- Reset: hold rst=1 for 2 cycles with pkt_valid=1 → detect_addr=1, busy=0, wr_en_req=0, dest_q=0.
- Clean packet, channel 2: NUM_CH=3, din=2, fifo_empty=3'b100, 4 payload cycles then pkt_valid=0 → states go DECODE_ADDRESS→LFD→LD×4→LOAD_PARITY→CHECK_PARITY_ERROR→DECODE_ADDRESS; dest_q=2; rst_int_reg high for exactly 1 cycle.
- Per-channel wait: din=1, fifo_empty=3'b101 → stays in WAIT_TILL_EMPTY. Set fifo_empty=3'b111 → LOAD_FIRST_DATA next cycle.
- Full path: fifo_full[0]=1 mid-LOAD_DATA → FIFO_FULL_STATE with busy=1. Clear it with low_pkt_valid=1 → LOAD_AFTER_FULL then LOAD_PARITY.
- Invalid address: din=3 with NUM_CH=3 → DROP_PACKET, drop_state=1, wr_en_req never asserts. pkt_valid=0 → DECODE_ADDRESS.
- Soft reset and timeout:
  - soft_rst=3'b010 while dest_q=2 in LOAD_DATA → ignored.
  - soft_rst=3'b100 → DECODE_ADDRESS next cycle.
  - With ROUTER_WAIT_TIMEOUT_EN and WAIT_TIMEOUT=4 → DROP_PACKET after 4 cycles in WAIT_TILL_EMPTY; wait_timeout is a single pulse.
